// File: rtl/pc_gen.sv
// Program-counter generator: prioritised redirect/exception/sequential next-PC with a one-entry pending redirect slot.
// Latency: pc updates one cycle after an accepted fetch; redirected/misalign pulse in the cycle the new pc/pend is loaded.
// Backpressure: pc is held stable while pc_valid & ~(pc_ready & ~stall); late redirects are queued in the pending slot.
module pc_gen #(
    parameter int              XLEN     = 32,
    parameter int              NSRC     = 3,
    parameter int              INC      = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_3000),
    parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(32'h0000_4180)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC-1:0]      src_req,
    input  logic [NSRC*XLEN-1:0] src_addr,
    input  logic                 exc_req,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 pc_ready,
    output logic [XLEN-1:0]      pc,
    output logic                 pc_valid,
    output logic [XLEN-1:0]      pc_plus,
    output logic                 redirected,
    output logic                 misalign
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] pend_addr;
    logic [XLEN-1:0] src_sel;
    logic [XLEN-1:0] target;
    logic            src_any;
    logic            src_mis;
    logic            tgt_mis;
    logic            redir;
    logic            acc;

    assign pc_plus = pc + XLEN'(INC);
    assign acc     = pc_valid & pc_ready & ~stall;

    // Later iterations overwrite earlier ones, so the highest requesting index wins.
    always_comb begin
        src_sel = '0;
        src_any = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_req[i]) begin
                src_any = 1'b1;
                src_sel = src_addr[i*XLEN +: XLEN];
            end
        end
        src_mis = src_any & (src_sel[1:0] != 2'b00);
        redir   = exc_req | src_any;
        tgt_mis = ~exc_req & src_mis;
        target  = (exc_req | src_mis) ? EXC_VEC : src_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pc_valid   <= 1'b0;
            pend_addr  <= '0;
            redirected <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            redirected <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN, HOLD: begin
                    // halt outranks src redirects but yields to an exception; leaving HOLD drops pend.
                    if (halt && !exc_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                    end else if (acc) begin
                        state <= RUN;
                        if (redir) begin
                            pc         <= target;
                            redirected <= 1'b1;
                            misalign   <= tgt_mis;
                        end else if (state == HOLD) begin
                            pc         <= pend_addr;
                            redirected <= 1'b1;
                        end else begin
                            pc <= pc_plus;
                        end
                    end else if (redir) begin
                        pend_addr <= target;
                        misalign  <= tgt_mis;
                        state     <= HOLD;
                    end
                end
                HALT: begin
                    if (exc_req) begin
                        pc         <= EXC_VEC;
                        pc_valid   <= 1'b1;
                        redirected <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
